// File: rtl/width_upsize.sv
// Narrow-to-wide stream packer: RATIO beats of IN_W bits -> one IN_W*RATIO word; optional
// partial flush on last_in with lane keep bits when WIDTH_UPSIZE_KEEP_EN is defined.
// Latency 1 cycle after the completing beat; ready_in = !valid_out || ready_out (zero-bubble).
module width_upsize #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [IN_W-1:0]       data_in,
    input  logic                  last_in,
    output logic                  ready_in,
    output logic                  valid_out,
    output logic [IN_W*RATIO-1:0] data_out,
    output logic [RATIO-1:0]      keep_out,
    output logic                  last_out,
    input  logic                  ready_out
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = $clog2(RATIO);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] word;
    logic [OUT_W-1:0] data_q;
    logic             valid_q;
    logic             in_xfer;
    logic             out_xfer;
    logic             last_cnt;
    logic             complete;

    function automatic int lane_lo(input int k);
        return (MSB_FIRST != 0) ? (RATIO - 1 - k) * IN_W : k * IN_W;
    endfunction

    assign ready_in = !valid_q || ready_out;
    assign in_xfer  = valid_in && ready_in;
    assign out_xfer = valid_q && ready_out;
    assign last_cnt = (cnt_q == CNT_W'(RATIO - 1));

`ifdef WIDTH_UPSIZE_KEEP_EN
    assign complete = in_xfer && (last_cnt || last_in);
`else
    logic unused_last_in;
    assign unused_last_in = last_in;
    assign complete = in_xfer && last_cnt;
`endif

    // Accumulator with the current beat merged into its lane; unfilled lanes are
    // already zero because the accumulator is cleared on every completion.
    always_comb begin
        word = acc_q;
        for (int k = 0; k < RATIO; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                word[lane_lo(k) +: IN_W] = data_in;
            end
        end
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (complete) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_xfer) begin
            acc_d = word;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (complete) begin
                data_q  <= word;
                valid_q <= 1'b1;
            end else if (out_xfer) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef WIDTH_UPSIZE_KEEP_EN
    logic [RATIO-1:0] keep_acc_q, keep_acc_d;
    logic [RATIO-1:0] keep_new;
    logic [RATIO-1:0] keep_q;
    logic             last_q;

    // Keep bits are in arrival order, independent of lane placement.
    assign keep_new = keep_acc_q | ({{(RATIO-1){1'b0}}, 1'b1} << cnt_q);

    always_comb begin
        keep_acc_d = keep_acc_q;
        if (complete) begin
            keep_acc_d = '0;
        end else if (in_xfer) begin
            keep_acc_d = keep_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keep_acc_q <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            keep_acc_q <= keep_acc_d;
            if (complete) begin
                keep_q <= keep_new;
                last_q <= last_in;
            end
        end
    end

    assign keep_out = keep_q;
    assign last_out = last_q;
`else
    assign keep_out = '1;
    assign last_out = 1'b0;
`endif

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule

// File: tb/tb_width_upsize.sv
// Randomized bench for width_upsize: two instances (RATIO=4 LSB-first, RATIO=2 MSB-first)
// share one input stream and are each compared every cycle against a beat-list model.
module tb_width_upsize;

`ifdef WIDTH_UPSIZE_KEEP_EN
    localparam bit KEEP_EN = 1'b1;
`else
    localparam bit KEEP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_in = 1'b0;
    logic [7:0]  data_in = '0;
    logic        last_in = 1'b0;
    logic        ready_out = 1'b1;

    logic        r0, v0, l0;
    logic [31:0] d0;
    logic [3:0]  k0;
    logic        r1, v1, l1;
    logic [15:0] d1;
    logic [1:0]  k1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    width_upsize #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
        .ready_in(r0), .valid_out(v0), .data_out(d0), .keep_out(k0), .last_out(l0),
        .ready_out(ready_out)
    );

    width_upsize #(.IN_W(8), .RATIO(2), .MSB_FIRST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
        .ready_in(r1), .valid_out(v1), .data_out(d1), .keep_out(k1), .last_out(l1),
        .ready_out(ready_out)
    );

    // Reference model: list of beats gathered so far plus the held output slot.
    int          R   [2] = '{4, 2};
    int          MSB [2] = '{0, 1};
    logic [7:0]  m_lane [2][4];
    int          m_n    [2];
    bit          m_valid[2];
    logic [63:0] m_data [2];
    logic [63:0] m_keep [2];
    bit          m_last [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i]     = 0;
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
            m_keep[i]  = KEEP_EN ? 64'd0 : (64'd1 << R[i]) - 64'd1;
            m_last[i]  = 1'b0;
        end
    endtask

    task automatic model_update(input int i);
        bit rdy, ox, done;
        logic [63:0] w;
        int pos;
        rdy  = !m_valid[i] || ready_out;
        ox   = m_valid[i] && ready_out;
        done = 1'b0;
        if (valid_in && rdy) begin
            m_lane[i][m_n[i]] = data_in;
            m_n[i]++;
            if (m_n[i] == R[i] || (KEEP_EN && last_in)) begin
                done = 1'b1;
                w = '0;
                for (int k = 0; k < m_n[i]; k++) begin
                    pos = (MSB[i] != 0) ? R[i] - 1 - k : k;
                    w = w | (64'(m_lane[i][k]) << (8 * pos));
                end
                m_data[i]  = w;
                m_keep[i]  = KEEP_EN ? (64'd1 << m_n[i]) - 64'd1 : (64'd1 << R[i]) - 64'd1;
                m_last[i]  = KEEP_EN && last_in;
                m_valid[i] = 1'b1;
                m_n[i]     = 0;
            end
        end
        if (!done && ox) m_valid[i] = 1'b0;
    endtask

    task automatic check_ready();
        chk("ready0", r0, !m_valid[0] || ready_out);
        chk("ready1", r1, !m_valid[1] || ready_out);
    endtask

    task automatic check_outs();
        chk("valid0", v0, m_valid[0]);
        chk("data0",  d0, m_data[0]);
        chk("keep0",  k0, m_keep[0]);
        chk("last0",  l0, m_last[0]);
        chk("valid1", v1, m_valid[1]);
        chk("data1",  d1, m_data[1]);
        chk("keep1",  k1, m_keep[1]);
        chk("last1",  l1, m_last[1]);
    endtask

    // Inputs are already driven; check combinational ready, take the edge, check outputs.
    task automatic step();
        #1;
        check_ready();
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check_outs();
    endtask

    task automatic beat(input logic [7:0] d, input bit l);
        valid_in = 1'b1;
        data_in  = d;
        last_in  = l;
        step();
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        last_in  = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        valid_in = 1'b0;
        last_in  = 1'b0;
        #1;
        model_reset();
        check_outs();
        check_ready();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        // Back-to-back pair into the 2:1 MSB-first instance.
        ready_out = 1'b1;
        beat(8'hAB, 1'b0);
        beat(8'hCD, 1'b0);
        chk("abcd_word", d1, 16'hABCD);
        chk("abcd_valid", v1, 1'b1);
        beat(8'hEF, 1'b0);
        beat(8'h01, 1'b0);

        // Gapped beats into the 4:1 LSB-first instance.
        beat(8'h11, 1'b0); idle();
        beat(8'h22, 1'b0); idle();
        beat(8'h33, 1'b0); idle();
        beat(8'h44, 1'b0);
        chk("w44332211", d0, 32'h44332211);
        idle();
        chk("single_cycle_valid", v0, 1'b0);

        // Backpressure, then release together with a new beat.
        ready_out = 1'b0;
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b0);
        for (int i = 0; i < 3; i++) beat(8'h77, 1'b0);
        ready_out = 1'b1;
        beat(8'h88, 1'b0);
        idle();

        // Partial flush request followed by an ordinary beat.
        beat(8'h12, 1'b1);
        beat(8'h34, 1'b0);
        idle(); idle(); idle();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            valid_in  = ($urandom_range(0, 9) < 7);
            data_in   = 8'($urandom);
            last_in   = ($urandom_range(0, 9) < 2);
            ready_out = ($urandom_range(0, 9) < 7);
            step();
        end

        // Reset with a partial word pending, then a clean word.
        ready_out = 1'b1;
        idle(); idle(); idle();
        model_reset();
        do_reset();
        beat(8'hB1, 1'b0);
        beat(8'hB2, 1'b0);
        beat(8'hB3, 1'b0);
        do_reset();
        beat(8'hC1, 1'b0);
        beat(8'hC2, 1'b0);
        beat(8'hC3, 1'b0);
        beat(8'hC4, 1'b0);
        chk("post_reset_word", d0, 32'hC4C3C2C1);
        chk("post_reset_valid", v0, 1'b1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
